// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and types for the max_seg7_display block:
//               blank pattern, active-low hex glyph table, scan state
//               encoding and a constant-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

   // All segments off (active-low).
   localparam logic [6:0] SEG7_BLANK = 7'h7F;

   // Hex glyphs, active-low, bit order {g,f,e,d,c,b,a}.
   // 'b' and 'd' are drawn lowercase so they differ from '8' and '0'.
   localparam logic [6:0] HEX_GLYPH [16] = '{
      7'h40, // 0
      7'h79, // 1
      7'h24, // 2
      7'h30, // 3
      7'h19, // 4
      7'h12, // 5
      7'h02, // 6
      7'h78, // 7
      7'h00, // 8
      7'h10, // 9
      7'h08, // A
      7'h03, // b
      7'h46, // C
      7'h21, // d
      7'h06, // E
      7'h0E  // F
   };

   // Scanner state: BLANK is only visited after reset.
   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SCAN  = 1'b1
   } scan_state_e;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg7
// Description : Combinational hex nibble to active-low 7-segment glyph.
// Ports       : nibble [3:0] in  - value 0..F
//               seg    [6:0] out - segments {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_GLYPH[nibble];

endmodule
`default_nettype wire

// File: rtl/max_seg7_display.sv
`default_nettype none
// ============================================================================
// Module      : max_seg7_display
// Description : Glitch-filters the CPU's 16-bit max result bus and shows the
//               settled value as four hex digits on a multiplexed
//               common-anode 7-segment display.
// Ports       : clk      in       system clock, rising edge
//               rst      in       asynchronous reset, active-low
//               max      in  [15] CPU result bus, may change any cycle
//               freeze   in       hold displayed value, ignore new values
//               an       out [3]  digit anodes, active-low
//               seg      out [6]  segments {g,f,e,d,c,b,a}, active-low
//               dp       out      decimal point, active-low (digit 0, frozen)
//               shown    out [15] value currently displayed
//               updated  out      one-cycle pulse after shown changes
// Revision    : 1.0 - initial release
// ============================================================================
module max_seg7_display
   import seg7_pkg::*;
#(
   parameter int CLK_HZ        = 50_000_000,
   parameter int SCAN_HZ       = 1_000,
   parameter int STABLE_CYCLES = 4,
   parameter int LZ_BLANK      = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] max,
   input  logic        freeze,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [15:0] shown,
   output logic        updated
);

   localparam int DIV    = CLK_HZ / SCAN_HZ;
   localparam int DIV_W  = (clog2(DIV) < 1) ? 1 : clog2(DIV);
   localparam int STAB_W = (clog2(STABLE_CYCLES) < 1) ? 1 : clog2(STABLE_CYCLES);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [15:0]       cand_q,     cand_d;
   logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
   logic [15:0]       shown_q,    shown_d;
   logic              updated_q,  updated_d;
   logic [DIV_W-1:0]  div_cnt_q,  div_cnt_d;
   scan_state_e       state_q,    state_d;   // ST_SCAN doubles as scan enable
   logic [1:0]        digit_q,    digit_d;
   logic [3:0]        an_q,       an_d;
   logic [6:0]        seg_q,      seg_d;
   logic              dp_q,       dp_d;

   logic              same;
   logic              accept;
   logic              tick;
   logic [3:0]        nibble;
   logic [6:0]        glyph;
   logic              lz_blank;

   // ------------------------------------------------------------------------
   // Stability filter
   // ------------------------------------------------------------------------
   always_comb begin
      cand_d     = cand_q;
      stab_cnt_d = stab_cnt_q;
      shown_d    = shown_q;

      same   = (max == cand_q);
      // The counter keeps running while frozen so a settled value is
      // accepted on the very first edge after freeze drops.
      accept = same && (stab_cnt_q == STAB_LAST) && (cand_q != shown_q) && !freeze;

      if (!same) begin
         cand_d     = max;
         stab_cnt_d = '0;
      end else if (stab_cnt_q != STAB_LAST) begin
         stab_cnt_d = stab_cnt_q + 1'b1;
      end

      if (accept) begin
         shown_d = cand_q;
      end
      updated_d = accept;
   end

   // ------------------------------------------------------------------------
   // Scan divider and digit sequencer
   // ------------------------------------------------------------------------
   always_comb begin
      tick      = (div_cnt_q == DIV_LAST);
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      state_d   = state_q;
      digit_d   = digit_q;

      if (tick) begin
         if (state_q == ST_BLANK) begin
            state_d = ST_SCAN;
            digit_d = 2'd0;
         end else begin
            digit_d = digit_q + 2'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Digit mux. Built from the next-state values so that anode, segments,
   // decimal point and displayed value all land in the same register update.
   // ------------------------------------------------------------------------
   always_comb begin
      case (digit_d)
         2'd0:    nibble = shown_d[3:0];
         2'd1:    nibble = shown_d[7:4];
         2'd2:    nibble = shown_d[11:8];
         default: nibble = shown_d[15:12];
      endcase
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble),
      .seg    (glyph)
   );

   generate
      if (LZ_BLANK != 0) begin : g_lz_blank
         // A digit is a leading zero when it and every higher nibble are 0;
         // digit 0 always stays lit so a zero value still reads "0".
         always_comb begin
            case (digit_d)
               2'd0:    lz_blank = 1'b0;
               2'd1:    lz_blank = (shown_d[15:4]  == 12'h000);
               2'd2:    lz_blank = (shown_d[15:8]  == 8'h00);
               default: lz_blank = (shown_d[15:12] == 4'h0);
            endcase
         end
      end else begin : g_no_lz_blank
         assign lz_blank = 1'b0;
      end
   endgenerate

   always_comb begin
      an_d  = 4'b1111;
      seg_d = SEG7_BLANK;
      dp_d  = 1'b1;
      if ((state_d == ST_SCAN) && !lz_blank) begin
         an_d  = ~(4'b0001 << digit_d);
         seg_d = glyph;
         dp_d  = !(freeze && (digit_d == 2'd0));
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand_q     <= '0;
         stab_cnt_q <= '0;
         shown_q    <= '0;
         updated_q  <= 1'b0;
         div_cnt_q  <= '0;
         state_q    <= ST_BLANK;
         digit_q    <= 2'd0;
         an_q       <= 4'b1111;
         seg_q      <= SEG7_BLANK;
         dp_q       <= 1'b1;
      end else begin
         cand_q     <= cand_d;
         stab_cnt_q <= stab_cnt_d;
         shown_q    <= shown_d;
         updated_q  <= updated_d;
         div_cnt_q  <= div_cnt_d;
         state_q    <= state_d;
         digit_q    <= digit_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign an      = an_q;
   assign seg     = seg_q;
   assign dp      = dp_q;
   assign shown   = shown_q;
   assign updated = updated_q;

endmodule
`default_nettype wire

// File: tb/tb_max_seg7_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_max_seg7_display
// Description : Self-checking bench for max_seg7_display (DIV=4, 4 stable
//               cycles). A window/edge-count reference model is compared
//               every cycle, alongside directed tables and sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_seg7_display;

   localparam int CLK_HZ  = 8;
   localparam int SCAN_HZ = 2;
   localparam int STABLE  = 4;
   localparam int DIV     = CLK_HZ / SCAN_HZ;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] max_in;
   logic        freeze;

   logic [3:0]  an_m,  an_z;
   logic [6:0]  seg_m, seg_z;
   logic        dp_m,  dp_z;
   logic [15:0] shown_m, shown_z;
   logic        upd_m, upd_z;

   always #5 clk = ~clk;

   max_seg7_display #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .STABLE_CYCLES(STABLE), .LZ_BLANK(0)) u_main (
      .clk(clk), .rst(rst), .max(max_in), .freeze(freeze),
      .an(an_m), .seg(seg_m), .dp(dp_m), .shown(shown_m), .updated(upd_m));

   max_seg7_display #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .STABLE_CYCLES(STABLE), .LZ_BLANK(1)) u_lz (
      .clk(clk), .rst(rst), .max(max_in), .freeze(freeze),
      .an(an_z), .seg(seg_z), .dp(dp_z), .shown(shown_z), .updated(upd_z));

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   int          m_n;        // clock edges since reset release
   logic [15:0] m_shown;
   logic        m_upd;
   logic        m_frz;
   logic [15:0] m_hist[$];  // last STABLE+1 samples of max

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
         4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
         4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
         4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit all_eq;
      bit acc;
      if (!rst) begin
         m_n = 0; m_shown = '0; m_upd = 1'b0; m_frz = 1'b0;
         m_hist.delete();
         for (int i = 0; i < STABLE + 1; i++) m_hist.push_back(16'h0000);
      end else begin
         m_n++;
         m_hist.push_back(max_in);
         void'(m_hist.pop_front());
         all_eq = 1'b1;
         foreach (m_hist[i]) if (m_hist[i] != max_in) all_eq = 1'b0;
         acc = all_eq && (max_in != m_shown) && !freeze;
         if (acc) m_shown = max_in;
         m_upd = acc;
         m_frz = freeze;
      end
   endtask

   task automatic exp_disp(input bit lz, output logic [3:0] e_an, output logic [6:0] e_seg, output logic e_dp);
      int t;
      int dg;
      logic [15:0] hi;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (m_n >= DIV) begin
         t  = m_n / DIV;
         dg = (t - 1) % 4;
         hi = m_shown >> (4 * dg);
         if (!(lz && dg > 0 && hi == 16'h0000)) begin
            e_an  = ~(4'b0001 << dg);
            e_seg = glyph(hi[3:0]);
            e_dp  = !(m_frz && dg == 0);
         end
      end
   endtask

   // One clock: advance model at the edge, compare #1 later.
   task automatic cycle();
      logic [3:0] ea; logic [6:0] es; logic ed;
      @(posedge clk);
      model_step();
      #1;
      chk("shown",   {16'h0, shown_m}, {16'h0, m_shown});
      chk("updated", {31'h0, upd_m},   {31'h0, m_upd});
      exp_disp(1'b0, ea, es, ed);
      chk("an",  {28'h0, an_m},  {28'h0, ea});
      chk("seg", {25'h0, seg_m}, {25'h0, es});
      chk("dp",  {31'h0, dp_m},  {31'h0, ed});
      exp_disp(1'b1, ea, es, ed);
      chk("lz_shown", {16'h0, shown_z}, {16'h0, m_shown});
      chk("lz_an",  {28'h0, an_z},  {28'h0, ea});
      chk("lz_seg", {25'h0, seg_z}, {25'h0, es});
      chk("lz_dp",  {31'h0, dp_z},  {31'h0, ed});
   endtask

   task automatic wait_an(input logic [3:0] val, input bit want_eq, input int bound);
      int k;
      k = 0;
      while (((an_m == val) != want_eq) && k < bound) begin
         cycle();
         k++;
      end
      chk("wait_an", {31'h0, ((an_m == val) == want_eq)}, 32'h1);
   endtask

   typedef struct {
      logic [15:0] val;
      logic        frz;
      int          hold;
      logic [15:0] exp_shown;
      int          exp_pulses;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[8];
      logic [3:0]  an_seq[5];
      logic [6:0]  seg_seq[5];
      int          pulses;
      bit          seen0, seen1;
      logic [15:0] v;
      int          h;

      vt[0] = '{16'h1111, 1'b0, 6, 16'h1111, 1};
      vt[1] = '{16'h1111, 1'b0, 6, 16'h1111, 0};  // equal to shown: no pulse
      vt[2] = '{16'h2222, 1'b0, 4, 16'h1111, 0};  // one cycle short
      vt[3] = '{16'h2222, 1'b0, 1, 16'h2222, 1};  // fifth edge accepts
      vt[4] = '{16'h3333, 1'b1, 8, 16'h2222, 0};  // frozen
      vt[5] = '{16'h3333, 1'b0, 1, 16'h3333, 1};  // release accepts next edge
      vt[6] = '{16'h0000, 1'b0, 5, 16'h0000, 1};
      vt[7] = '{16'hFFFF, 1'b0, 5, 16'hFFFF, 1};

      an_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      seg_seq = '{7'h0E,   7'h06,   7'h06,   7'h03,   7'h0E};

      // ---- 1: reset ----
      rst = 1'b0; max_in = 16'h0000; freeze = 1'b0;
      repeat (3) cycle();
      chk("rst_shown", {16'h0, shown_m}, 32'h0);
      chk("rst_an",    {28'h0, an_m},    32'hF);
      chk("rst_seg",   {25'h0, seg_m},   32'h7F);
      chk("rst_dp",    {31'h0, dp_m},    32'h1);
      rst = 1'b1;
      for (int i = 1; i <= DIV; i++) begin
         cycle();
         if (i < DIV) chk("blank_an", {28'h0, an_m}, 32'hF);
      end
      chk("first_an",  {28'h0, an_m},  32'hE);
      chk("first_seg", {25'h0, seg_m}, 32'h40);

      // ---- 2: BEEF latency and digit walk ----
      max_in = 16'hBEEF;
      for (int k = 1; k <= 6; k++) begin
         cycle();
         if (k < 5)  chk("beef_early", {31'h0, shown_m == 16'hBEEF}, 32'h0);
         if (k == 5) begin
            chk("beef_shown", {16'h0, shown_m}, 32'hBEEF);
            chk("beef_upd",   {31'h0, upd_m},   32'h1);
         end
         if (k == 6) chk("beef_upd_off", {31'h0, upd_m}, 32'h0);
      end
      wait_an(4'b1110, 1'b0, 20);
      wait_an(4'b1110, 1'b1, 20);
      chk("walk_seg0", {25'h0, seg_m}, {25'h0, seg_seq[0]});
      for (int i = 1; i < 5; i++) begin
         repeat (DIV) cycle();
         chk("walk_an",  {28'h0, an_m},  {28'h0, an_seq[i]});
         chk("walk_seg", {25'h0, seg_m}, {25'h0, seg_seq[i]});
      end

      // ---- 3: glitch rejection ----
      pulses = 0;
      max_in = 16'h1234;
      repeat (3) begin
         cycle(); pulses += int'(upd_m);
         chk("glitch_never", {31'h0, shown_m == 16'h1234}, 32'h0);
      end
      max_in = 16'h5678;
      repeat (5) begin
         cycle(); pulses += int'(upd_m);
         chk("glitch_never", {31'h0, shown_m == 16'h1234}, 32'h0);
      end
      chk("glitch_shown",  {16'h0, shown_m}, 32'h5678);
      chk("glitch_pulses", pulses, 1);

      // ---- 4: freeze ----
      max_in = 16'h1234;
      repeat (6) cycle();
      chk("frz_pre", {16'h0, shown_m}, 32'h1234);
      freeze = 1'b1; max_in = 16'hABCD; seen0 = 1'b0;
      repeat (20) begin
         cycle();
         chk("frz_hold", {16'h0, shown_m}, 32'h1234);
         if (an_m == 4'b1110) begin
            seen0 = 1'b1;
            chk("frz_dp_on", {31'h0, dp_m}, 32'h0);
         end else begin
            chk("frz_dp_off", {31'h0, dp_m}, 32'h1);
         end
      end
      chk("frz_seen_d0", {31'h0, seen0}, 32'h1);
      freeze = 1'b0;
      cycle();
      chk("frz_rel_shown", {16'h0, shown_m}, 32'hABCD);
      chk("frz_rel_upd",   {31'h0, upd_m},   32'h1);
      cycle();
      chk("frz_rel_upd_off", {31'h0, upd_m}, 32'h0);

      // ---- table vectors ----
      for (int e = 0; e < 8; e++) begin
         max_in = vt[e].val; freeze = vt[e].frz; pulses = 0;
         repeat (vt[e].hold) begin
            cycle(); pulses += int'(upd_m);
         end
         chk($sformatf("vec%0d_shown", e), {16'h0, shown_m}, {16'h0, vt[e].exp_shown});
         chk($sformatf("vec%0d_pulses", e), pulses, vt[e].exp_pulses);
      end
      freeze = 1'b0;

      // ---- 5: leading-zero blanking ----
      max_in = 16'h0042;
      repeat (6) cycle();
      chk("lz_val", {16'h0, shown_z}, 32'h0042);
      seen0 = 1'b0; seen1 = 1'b0;
      repeat (24) begin
         cycle();
         chk("lz_hi_off", {30'h0, an_z[3:2]}, 32'h3);
         if (an_z == 4'b1110) begin seen0 = 1'b1; chk("lz_d0", {25'h0, seg_z}, 32'h24); end
         if (an_z == 4'b1101) begin seen1 = 1'b1; chk("lz_d1", {25'h0, seg_z}, 32'h19); end
      end
      chk("lz_seen", {30'h0, seen1, seen0}, 32'h3);
      max_in = 16'h0000;
      repeat (6) cycle();
      seen0 = 1'b0;
      repeat (20) begin
         cycle();
         chk("lz0_only_d0", {31'h0, (an_z == 4'b1110) || (an_z == 4'b1111)}, 32'h1);
         if (an_z == 4'b1110) begin seen0 = 1'b1; chk("lz0_seg", {25'h0, seg_z}, 32'h40); end
      end
      chk("lz0_seen", {31'h0, seen0}, 32'h1);

      // ---- random stimulus against model ----
      for (int s = 0; s < 70; s++) begin
         case ($urandom_range(0, 4))
            0: v = 16'h0000;
            1: v = 16'h1234;
            2: v = 16'h00A0;
            3: v = 16'hBEEF;
            default: v = 16'($urandom);
         endcase
         max_in = v;
         freeze = ($urandom_range(0, 5) == 0);
         h = $urandom_range(1, 7);
         repeat (h) cycle();
      end
      freeze = 1'b0;

      // ---- 6: async reset mid-scan ----
      max_in = 16'hBEEF;
      repeat (8) cycle();
      wait_an(4'b1111, 1'b0, 20);
      #2;
      rst = 1'b0;
      #1;
      chk("async_shown", {16'h0, shown_m}, 32'h0);
      chk("async_an",    {28'h0, an_m},    32'hF);
      chk("async_seg",   {25'h0, seg_m},   32'h7F);
      chk("async_dp",    {31'h0, dp_m},    32'h1);
      chk("async_upd",   {31'h0, upd_m},   32'h0);
      chk("async_lz_an", {28'h0, an_z},    32'hF);
      repeat (2) cycle();
      rst = 1'b1;
      for (int i = 1; i <= DIV; i++) begin
         cycle();
         if (i < DIV) chk("restart_blank", {28'h0, an_m}, 32'hF);
      end
      chk("restart_an",  {28'h0, an_m},  32'hE);
      chk("restart_seg", {25'h0, seg_m}, 32'h40);
      repeat (8) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
